seq_adder_arbiter: RTL and testbench
====================================

Name: seq_adder_arbiter

Overview:
- Shares one bit-serial add engine between N requesters.
- Round-robin arbitration; grants one requester at a time and latches its operands.
- Sequences the engine LSB-first over WIDTH cycles, then returns {C_out,S} tagged with the requester id.
- Sits between multiple ALU clients and the single serial adder resource. The engine is internal: one full adder plus shift registers.

Parameters:
- WIDTH, 3, operand width in bits (>=1).
- N, 4, number of requesters (>=2). ID_W = max(1, $clog2(N)) is a localparam.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request level; held with operands until granted
- A_bus  in  N*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- B_bus  in  N*WIDTH  operand B, same packing as A_bus
- C_in_bus  in  N  carry-in; requester i at bit i
- gnt  out  N  one-hot accept pulse; operands latched on this edge
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse; result valid
- done_id  out  ID_W  index of the requester whose result is presented
- S  out  WIDTH  sum; holds until the next completion
- C_out  out  1  carry out; holds until the next completion

Behaviour:
- Reset (clk edge with rst=1) applies in every state:
  - state=IDLE, gnt=0, busy=0, done=0, done_id=0, S=0, C_out=0, bit counter=0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - Reset mid-operation aborts it: no done pulse, and the partial result is discarded.
- States:
  - IDLE: gnt is combinational, equal to the winner among req; 0 if req==0.
    - If any req is set, on the edge: latch A/B/C_in of the winner and its id, pointer = winner, counter=0, go to RUN.
  - RUN: each cycle add bit[cnt] of A and B plus the carry register; shift the sum bit into the sum register MSB-first (so the LSB ends at bit 0); update carry; cnt++.
    - When cnt==WIDTH-1, on the edge: write S, C_out and done_id, go to DONE.
  - DONE: done=1 for exactly one cycle. Next state is IDLE. No grant is issued in DONE.
- Latency:
  - gnt in cycle T; done in cycle T+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles.
- Arbitration:
  - The winner is the first requester with req set, searching from (pointer+1) mod N upward with wrap-around.
  - Requesters not granted keep waiting; no starvation. Every waiting requester is served within N grants.
- Handshake:
  - A requester must drop req, or present new operands, after its gnt edge. If req is still high in the next IDLE, it counts as a new request.
  - req may drop before grant without side effects.
  - gnt is never asserted outside IDLE. Operand changes during RUN/DONE do not affect the result in flight.
- Arithmetic: {C_out,S} = A + B + C_in, exact over WIDTH+1 bits. Max case: 7+7+1 = 15 gives C_out=1, S=7 at WIDTH=3.
- Outputs S, C_out and done_id are registered and hold their last result in IDLE, RUN and DONE until overwritten.

Optional Feature:
- Macro: SEQ_ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requester with req set always wins, and the pointer is unused.
- Undefined (default): round-robin as described above.
- Everything else is identical: timing, handshake, outputs.

Test Plan:
- Single op (WIDTH=3, N=4): req=0001, A0=5, B0=6, C0=1 at cycle T.
  - Response: gnt=0001 at T, busy=1 from T+1, done=1 at T+4 only, S=4, C_out=1, done_id=0, busy=0 at T+5.
- Round-robin: req=1111 held throughout, distinct operands per requester.
  - Response: grants in order 0,1,2,3,0, spaced 5 cycles apart. Each done_id matches its grant, and each {C_out,S} is correct.
- Fixed priority (macro defined): req=1111 held.
  - Response: every grant is 0001.
  - Then req=1100: next grant is 0100.
- Reset mid-op: grant requester 1 (A=3, B=2, C_in=0), assert rst in the second RUN cycle.
  - Response: no done pulse; S=0, C_out=0, busy=0 after reset.
  - Then req=1111: first grant is 0001.
- Exhaustive via requester 2: all A,B in 0..7 and C_in in 0..1 (128 ops).
  - Response: every done has done_id=2 and {C_out,S} = A+B+C_in. Includes 7+7+1 giving C_out=1, S=7 and 0+0+0 giving 0.
- Late request: req3 rises during RUN of requester 0's op.
  - Response: gnt=1000 in the IDLE cycle after done; requester 0's result is unaffected.

Source files
------------

// File: rtl/seq_adder_arbiter.sv
// N requesters share one bit-serial full adder; round-robin grant, LSB-first add over WIDTH cycles.
// Define SEQ_ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module seq_adder_arbiter #(
  parameter int WIDTH = 3,
  parameter int N     = 4,
  localparam int ID_W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   A_bus,
  input  logic [N*WIDTH-1:0]   B_bus,
  input  logic [N-1:0]         C_in_bus,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic [WIDTH-1:0]     S,
  output logic                 C_out
);
  localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [ID_W-1:0]  id_q, id_d, done_id_q, done_id_d;
  logic [ID_W-1:0]  win;
  logic             any_req;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] sum_sh;

`ifdef SEQ_ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i]) win = ID_W'(i);
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Scan from farthest to nearest so the first match after ptr is the last assignment.
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) win = ID_W'(idx);
    end
  end
`endif

  assign any_req = |req;

  // Serial full adder on the current bit; the sum enters at the MSB and shifts down.
  assign s_bit = a_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
  assign c_bit = (a_q[cnt_q] & b_q[cnt_q]) | (carry_q & (a_q[cnt_q] ^ b_q[cnt_q]));
  always_comb begin
    sum_sh = sum_q >> 1;
    sum_sh[WIDTH-1] = s_bit;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    id_d      = id_q;
    s_d       = s_q;
    cout_d    = cout_q;
    done_id_d = done_id_q;
    gnt       = '0;
`ifndef SEQ_ADDER_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: if (any_req) begin
        gnt[win] = 1'b1;
        a_d      = A_bus[int'(win)*WIDTH +: WIDTH];
        b_d      = B_bus[int'(win)*WIDTH +: WIDTH];
        carry_d  = C_in_bus[win];
        id_d     = win;
        sum_d    = '0;
        cnt_d    = '0;
`ifndef SEQ_ADDER_ARB_FIXED_PRIO_EN
        ptr_d    = win;
`endif
        state_d  = RUN;
      end
      RUN: begin
        sum_d   = sum_sh;
        carry_d = c_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          s_d       = sum_sh;
          cout_d    = c_bit;
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      id_q      <= '0;
      s_q       <= '0;
      cout_q    <= 1'b0;
      done_id_q <= '0;
`ifndef SEQ_ADDER_ARB_FIXED_PRIO_EN
      ptr_q     <= ID_W'(N-1);
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      s_q       <= s_d;
      cout_q    <= cout_d;
      done_id_q <= done_id_d;
`ifndef SEQ_ADDER_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign S       = s_q;
  assign C_out   = cout_q;
endmodule

// File: tb/tb_seq_adder_arbiter.sv
// Directed bench for seq_adder_arbiter: expected results queued at grant, checked on done.
module tb_seq_adder_arbiter;
  localparam int WIDTH = 3;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] A_bus, B_bus;
  logic [N-1:0]       C_in_bus;
  logic [N-1:0]       gnt;
  logic               busy, done;
  logic [1:0]         done_id;
  logic [WIDTH-1:0]   S;
  logic               C_out;

  logic [WIDTH-1:0] a_op [N];
  logic [WIDTH-1:0] b_op [N];
  logic             c_op [N];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int sb [$];

  seq_adder_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .A_bus(A_bus), .B_bus(B_bus),
    .C_in_bus(C_in_bus), .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .S(S), .C_out(C_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      A_bus[i*WIDTH +: WIDTH] = a_op[i];
      B_bus[i*WIDTH +: WIDTH] = b_op[i];
      C_in_bus[i]             = c_op[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int expv(input int id, input int a, input int b, input int c);
    return id*16 + a + b + c;
  endfunction

  task automatic push_op(input int id);
    sb.push_back(expv(id, int'(a_op[id]), int'(b_op[id]), int'(c_op[id])));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Scoreboard: every done pops the oldest expected {id, C_out, S}.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else chk("result", {26'd0, done_id, C_out, S}, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0; b_op[i] = '0; c_op[i] = 1'b0;
    end
    cyc();
    do_reset();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_Cout", C_out, 0);
    chk("rst_done_id", done_id, 0);

    // Single op: 5+6+1 = 12 -> C_out=1, S=4
    cyc();
    req = 4'b0001; a_op[0] = 3'd5; b_op[0] = 3'd6; c_op[0] = 1'b1;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0001);
    chk("single_busy_T", busy, 0);
    push_op(0);
    cyc(); req = '0;
    @(negedge clk);
    chk("single_busy_T1", busy, 1);
    chk("single_gnt_run", gnt, 0);
    cyc(); @(negedge clk); chk("single_done_T2", done, 0);
    cyc(); @(negedge clk); chk("single_done_T3", done, 0);
    cyc(); @(negedge clk); chk("single_done_T4", done, 1);
    cyc(); @(negedge clk);
    chk("single_done_T5", done, 0);
    chk("single_busy_T5", busy, 0);
    chk("single_hold", {C_out, S}, 12);

`ifdef SEQ_ADDER_ARB_FIXED_PRIO_EN
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_op[i] = WIDTH'(i+1); b_op[i] = WIDTH'(2*i+1); c_op[i] = i[0];
    end
    req = 4'b1111;
    for (int g = 0; g < 3; g++) begin
      if (g != 0) repeat (5) cyc();
      @(negedge clk);
      chk("fixed_gnt", gnt, 4'b0001);
      push_op(0);
    end
    cyc(); req = 4'b1100;
    repeat (4) cyc();
    @(negedge clk);
    chk("fixed_gnt_1100", gnt, 4'b0100);
    push_op(2);
    cyc(); req = '0;
    drain();
`else
    // Round-robin with all requesters held high.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_op[i] = WIDTH'(i+1); b_op[i] = WIDTH'(2*i+1); c_op[i] = i[0];
    end
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      if (g != 0) repeat (5) cyc();
      @(negedge clk);
      oh = 4'b0001 << (g % N);
      chk("rr_gnt", gnt, oh);
      push_op(g % N);
      if (g == 0) begin
        cyc(); @(negedge clk); chk("rr_no_gnt_run", gnt, 0);
        repeat (4) cyc();
        @(negedge clk);
        chk("rr_gnt", gnt, 4'b0010);
        push_op(1);
        g = 1;
      end
    end
    cyc(); req = '0;
    drain();
`endif

    // Reset mid-op aborts requester 1's addition.
    req = 4'b0010; a_op[1] = 3'd3; b_op[1] = 3'd2; c_op[1] = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", gnt, 4'b0010);
    cyc(); req = '0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_S", S, 0);
    chk("midrst_Cout", C_out, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); @(negedge clk); chk("midrst_no_done", done, 0);
    end
    cyc();
    req = 4'b1111;
    @(negedge clk);
    chk("midrst_first_gnt", gnt, 4'b0001);
    push_op(0);
    cyc(); req = '0;
    drain();

    // Exhaustive sweep through requester 2.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++) begin
          a_op[2] = WIDTH'(a); b_op[2] = WIDTH'(b); c_op[2] = c[0];
          req = 4'b0100;
          @(negedge clk);
          chk("exh_gnt", gnt, 4'b0100);
          sb.push_back(expv(2, a, b, c));
          cyc(); req = '0;
          repeat (4) cyc();
        end
    drain();

    // Late request from requester 3 while requester 0 runs; A0 changes mid-flight.
    do_reset();
    req = 4'b0001; a_op[0] = 3'd2; b_op[0] = 3'd3; c_op[0] = 1'b0;
    @(negedge clk);
    chk("late_gnt0", gnt, 4'b0001);
    push_op(0);
    cyc(); req = '0; a_op[0] = 3'd7;
    cyc(); req = 4'b1000; a_op[3] = 3'd7; b_op[3] = 3'd1; c_op[3] = 1'b1;
    @(negedge clk); chk("late_no_gnt_run", gnt, 0);
    cyc(); cyc();
    @(negedge clk); chk("late_no_gnt_done", gnt, 0);
    cyc();
    @(negedge clk);
    chk("late_gnt3", gnt, 4'b1000);
    push_op(3);
    cyc(); req = '0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
